sha1_arbiter: RTL and testbench

SHA1_ARBITER -- requirements
Module: sha1_arbiter

---
 rtl/sha1_arb_pkg.sv | 14 +
 rtl/sha1_arbiter_rr_pick2.sv | 13 +
 rtl/sha1_arbiter.sv | 159 +++++++++++++++
 tb/tb_sha1_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_arb_pkg.sv
// Shared types and constants for the two-requester SHA-1 core arbiter.
package sha1_arb_pkg;
   localparam int WORDS    = 16;
   localparam int TIMEOUT  = 255;
   localparam int DIGEST_W = 160;
   localparam int WORD_W   = 32;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STREAM  = 2'd1,
      S_WAIT    = 2'd2,
      S_DELIVER = 2'd3
   } state_e;
endpackage

// File: rtl/sha1_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the requester that did not own last wins.
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] win_o
);
   always_comb begin
      win_o = req_i;
      if (req_i == 2'b11) begin
         win_o = last_i ? 2'b01 : 2'b10;
      end
   end
endmodule

// File: rtl/sha1_arbiter.sv
// Shares one SHA-1 core between two block requesters: streams the owner's words,
// waits for a fresh digest-ready (with watchdog), then pulses done or error.
module sha1_arbiter
   import sha1_arb_pkg::*;
#(
   parameter int WORDS   = sha1_arb_pkg::WORDS,
   parameter int TIMEOUT = sha1_arb_pkg::TIMEOUT
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          req,
   input  logic [1:0]          vld,
   input  logic [WORD_W-1:0]   dat0,
   input  logic [WORD_W-1:0]   dat1,
   output logic [1:0]          grant,
   output logic                sha_initial,
   output logic                sha_valid,
   output logic [WORD_W-1:0]   sha_dat,
   input  logic                sha_ready,
   input  logic [DIGEST_W-1:0] sha_digest,
   output logic [DIGEST_W-1:0] digest,
   output logic [1:0]          done,
   output logic [1:0]          error
);
   state_e              state_q, state_d;
   logic [1:0]          grant_q, grant_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [7:0]          wdog_q, wdog_d;
   logic                seen_low_q, seen_low_d;
   logic [DIGEST_W-1:0] digest_q, digest_d;
   logic [1:0]          win;
   logic [1:0]          owner_oh;
   logic                own_req;
   logic                own_vld;

   rr_pick2 u_pick (
      .req_i  (req),
      .last_i (last_q),
      .win_o  (win)
   );

   assign owner_oh = owner_q ? 2'b10 : 2'b01;
   assign own_req  = req[owner_q];
   assign own_vld  = vld[owner_q];
   assign grant    = grant_q;
   assign digest   = digest_q;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      wdog_d      = wdog_q;
      seen_low_d  = seen_low_q;
      digest_d    = digest_q;
      sha_valid   = 1'b0;
      sha_initial = 1'b0;
      sha_dat     = owner_q ? dat1 : dat0;
      done        = 2'b00;
      error       = 2'b00;

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               grant_d = win;
               owner_d = win[1];
               cnt_d   = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            sha_valid   = own_vld;
            sha_initial = own_vld && (cnt_q == 4'd0);
            if (!own_req) begin
               state_d = S_IDLE;
               grant_d = 2'b00;
               last_d  = owner_q;
               cnt_d   = '0;
            end else if (own_vld) begin
               if (cnt_q == 4'(WORDS - 1)) begin
                  cnt_d      = '0;
                  wdog_d     = '0;
                  seen_low_d = 1'b0;
                  state_d    = S_WAIT;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_WAIT: begin
            // A ready already high on entry belongs to an earlier block; require a low first.
            if (!own_req) begin
               state_d    = S_IDLE;
               grant_d    = 2'b00;
               last_d     = owner_q;
               wdog_d     = '0;
               seen_low_d = 1'b0;
            end else if (seen_low_q && sha_ready) begin
               digest_d = sha_digest;
               state_d  = S_DELIVER;
            end else if (wdog_q == 8'(TIMEOUT)) begin
               error   = owner_oh;
               grant_d = 2'b00;
               last_d  = owner_q;
               wdog_d  = '0;
               state_d = S_IDLE;
            end else begin
               wdog_d = wdog_q + 8'd1;
               if (!sha_ready) begin
                  seen_low_d = 1'b1;
               end
            end
         end
         S_DELIVER: begin
            done       = owner_oh;
            grant_d    = 2'b00;
            last_d     = owner_q;
            seen_low_d = 1'b0;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = 2'b00;
         end
      endcase

      if (!reset_n) begin
         sha_valid   = 1'b0;
         sha_initial = 1'b0;
         done        = 2'b00;
         error       = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         grant_q    <= 2'b00;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= '0;
         wdog_q     <= '0;
         seen_low_q <= 1'b0;
         digest_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         wdog_q     <= wdog_d;
         seen_low_q <= seen_low_d;
         digest_q   <= digest_d;
      end
   end
endmodule

// File: tb/tb_sha1_arbiter.sv
// Directed bench for sha1_arbiter: expected words and completion pulses are queued by stimulus
// and checked by an independent monitor; timing points are checked inline.
module tb_sha1_arbiter;
   logic         clk = 1'b0;
   logic         reset_n;
   logic [1:0]   req, vld;
   logic [31:0]  dat0, dat1;
   logic [1:0]   grant;
   logic         sha_initial, sha_valid;
   logic [31:0]  sha_dat;
   logic         sha_ready;
   logic [159:0] sha_digest, digest;
   logic [1:0]   done, error;

   always #5 clk = ~clk;

   sha1_arbiter #(.WORDS(16), .TIMEOUT(255)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .vld(vld), .dat0(dat0), .dat1(dat1),
      .grant(grant), .sha_initial(sha_initial), .sha_valid(sha_valid), .sha_dat(sha_dat),
      .sha_ready(sha_ready), .sha_digest(sha_digest), .digest(digest), .done(done), .error(error)
   );

   typedef struct packed { logic [31:0] d; logic ini; } wd_t;
   typedef struct packed { logic [1:0] dn; logic [1:0] er; logic [159:0] dg; } ev_t;

   wd_t wd_q[$];
   ev_t ev_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   localparam logic [159:0] DG1 = {5{32'hA1B2_C3D4}};
   localparam logic [159:0] DG2 = {5{32'h1234_5678}};
   localparam logic [159:0] DG3 = {5{32'hCAFE_F00D}};
   localparam logic [159:0] DG4 = {5{32'h0BAD_BEEF}};
   localparam logic [159:0] DGX = {5{32'hDEAD_DEAD}};

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] oh(input int r);
      return (r == 0) ? 2'b01 : 2'b10;
   endfunction

   // Monitor: compares every presented word and every done/error pulse against the queues.
   initial begin : monitor
      wd_t w;
      ev_t e;
      forever begin
         @(negedge clk);
         if (sha_valid === 1'b1) begin
            if (wd_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_word: got sha_dat %0h, none expected", sha_dat);
            end else begin
               w = wd_q.pop_front();
               check("word_dat", 160'(sha_dat), 160'(w.d));
               check("word_initial", 160'(sha_initial), 160'(w.ini));
            end
         end
         if ((done | error) !== 2'b00) begin
            if (ev_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_pulse: got done %b error %b, none expected", done, error);
            end else begin
               e = ev_q.pop_front();
               check("pulse_done", 160'(done), 160'(e.dn));
               check("pulse_error", 160'(error), 160'(e.er));
               check("pulse_digest", digest, e.dg);
            end
         end
      end
   end

   task automatic stream(input int r, input logic [31:0] base, input bit gappy, input int n);
      for (int i = 0; i < n; i++) begin
         vld[r] = 1'b1;
         if (r == 0) dat0 = base + 32'(i);
         else        dat1 = base + 32'(i);
         wd_q.push_back('{d: base + 32'(i), ini: (i == 0)});
         tick();
         if (gappy && i != n - 1) begin
            vld[r] = 1'b0;
            tick();
         end
      end
      vld[r] = 1'b0;
   endtask

   task automatic wait_evt(input string name, input int budget, output int cycles);
      cycles = 0;
      while ((done | error) == 2'b00 && cycles < budget) begin
         tick();
         cycles++;
      end
      if ((done | error) == 2'b00) begin
         n_checks++; n_fail++;
         $display("FAIL %s: no done/error within %0d cycles", name, budget);
      end
   endtask

   task automatic finish_core(input int r, input int delay, input logic [159:0] dg);
      int c;
      repeat (delay) tick();
      sha_digest = dg;
      sha_ready  = 1'b1;
      ev_q.push_back('{dn: oh(r), er: 2'b00, dg: dg});
      wait_evt("deliver_wait", 4, c);
      check("deliver_latency", 160'(c), 160'd1);
      req[r]    = 1'b0;
      sha_ready = 1'b0;
      tick();
      check("grant_clear_after_done", 160'(grant), 160'd0);
      check("done_single_cycle", 160'(done), 160'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin : stim
      int c;
      reset_n = 1'b0; req = 2'b00; vld = 2'b11; dat0 = '0; dat1 = '0;
      sha_ready = 1'b0; sha_digest = '0;
      repeat (3) tick();
      check("rst_grant", 160'(grant), 160'd0);
      check("rst_done", 160'(done), 160'd0);
      check("rst_error", 160'(error), 160'd0);
      check("rst_digest", digest, 160'd0);
      check("rst_sha_valid", 160'(sha_valid), 160'd0);
      check("rst_sha_initial", 160'(sha_initial), 160'd0);
      vld = 2'b00;
      reset_n = 1'b1;
      tick();

      // Single request, words 0..15, core ready 80 cycles into WAIT.
      req = 2'b01;
      tick();
      check("single_grant", 160'(grant), 160'b01);
      stream(0, 32'h0, 1'b0, 16);
      finish_core(0, 80, DG1);
      check("single_digest", digest, DG1);

      // Contention from reset: 01, 10, 01; non-owner vld carries junk.
      do_reset();
      req = 2'b11; vld = 2'b10; dat1 = 32'hEEEE_0000;
      tick();
      check("contend_grant0", 160'(grant), 160'b01);
      stream(0, 32'h100, 1'b0, 16);
      vld = 2'b00;
      finish_core(0, 5, DG2);
      tick();
      check("contend_grant1", 160'(grant), 160'b10);
      req[0] = 1'b1; vld[0] = 1'b1; dat0 = 32'hEEEE_1111;
      stream(1, 32'h200, 1'b1, 16);
      vld = 2'b00;
      finish_core(1, 3, DG3);
      check("contend_digest1", digest, DG3);
      tick();
      check("contend_grant2", 160'(grant), 160'b01);

      // Timeout on requester 0 while requester 1 waits.
      req[1] = 1'b1;
      stream(0, 32'h300, 1'b0, 16);
      ev_q.push_back('{dn: 2'b00, er: 2'b01, dg: DG3});
      wait_evt("timeout_wait", 300, c);
      check("timeout_cycles", 160'(c), 160'd255);
      tick();
      check("timeout_grant_clear", 160'(grant), 160'd0);
      check("timeout_digest_kept", digest, DG3);
      tick();
      check("timeout_next_grant", 160'(grant), 160'b10);
      req[0] = 1'b0;

      // Stale ready: high at WAIT entry must not deliver.
      sha_digest = DGX;
      sha_ready  = 1'b1;
      stream(1, 32'h400, 1'b0, 16);
      tick();
      check("stale_no_done_a", 160'(done), 160'd0);
      tick();
      check("stale_no_done_b", 160'(done), 160'd0);
      sha_ready = 1'b0;
      repeat (3) tick();
      finish_core(1, 0, DG4);
      check("stale_digest", digest, DG4);

      // Abort after word 7, then last owner favours requester 1.
      req = 2'b01;
      tick();
      check("abort_grant", 160'(grant), 160'b01);
      stream(0, 32'h500, 1'b0, 8);
      req = 2'b00;
      tick();
      check("abort_grant_clear", 160'(grant), 160'd0);
      check("abort_no_done", 160'(done), 160'd0);
      check("abort_no_error", 160'(error), 160'd0);
      check("abort_no_valid", 160'(sha_valid), 160'd0);
      req = 2'b11;
      tick();
      check("abort_next_grant", 160'(grant), 160'b10);
      req[0] = 1'b0;

      // Reset during WAIT drops everything; afterwards requester 0 wins the tie again.
      stream(1, 32'h600, 1'b0, 16);
      tick();
      reset_n = 1'b0;
      tick();
      check("midrst_grant", 160'(grant), 160'd0);
      check("midrst_done", 160'(done), 160'd0);
      check("midrst_error", 160'(error), 160'd0);
      check("midrst_digest", digest, 160'd0);
      check("midrst_valid", 160'(sha_valid), 160'd0);
      reset_n = 1'b1;
      req = 2'b11;
      tick();
      check("post_rst_grant", 160'(grant), 160'b01);
      req = 2'b00;
      repeat (3) tick();

      check("words_all_seen", 160'(wd_q.size()), 160'd0);
      check("pulses_all_seen", 160'(ev_q.size()), 160'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : guard
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
